// File: rtl/debug_view_sequencer_pkg.sv
// Shared select codes, source count and mode encoding for the debug display path.
package debug_pkg;

   localparam logic [2:0] SEL_RDATA1 = 3'd0;
   localparam logic [2:0] SEL_RDATA2 = 3'd1;
   localparam logic [2:0] SEL_RESULT = 3'd2;
   localparam logic [2:0] SEL_WDATA  = 3'd3;
   localparam logic [2:0] SEL_NEXTPC = 3'd4;

   localparam int unsigned NUM_SRC = 5;

   typedef enum logic {
      MANUAL = 1'b0,
      AUTO   = 1'b1
   } mode_e;

   // Next select code in the auto-scan rotation, wrapping after the last source.
   function automatic logic [2:0] next_sel(input logic [2:0] cur, input int unsigned n);
      return (32'(cur) >= n - 1) ? SEL_RDATA1 : cur + 3'd1;
   endfunction

endpackage

// File: rtl/debug_view_sequencer_key_debouncer.sv
// Pushbutton conditioner: 2-flop synchroniser, level debouncer and rising-edge pulse.
module key_debouncer #(
   parameter int unsigned DB_CYCLES = 500_000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic stable,
   output logic rise_pulse
);

   localparam int unsigned CW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          stable_q;
   logic [CW-1:0] cnt;

   // Bring the asynchronous key into the clock domain.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after DB_CYCLES consecutive differing samples.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable <= 1'b0;
         cnt    <= '0;
      end else if (sync2 != stable) begin
         if (cnt == CNT_LAST) begin
            stable <= sync2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end else begin
         cnt <= '0;
      end
   end

   // One-cycle pulse in the cycle after the stable level rises.
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_q   <= 1'b0;
         rise_pulse <= 1'b0;
      end else begin
         stable_q   <= stable;
         rise_pulse <= stable & ~stable_q;
      end
   end

endmodule

// File: rtl/debug_view_sequencer.sv
// Debug display sequencer: manual/auto-scan source select plus debounced CPU step control.
module debug_view_sequencer #(
   parameter int unsigned DWELL     = 50_000_000,
   parameter int unsigned DB_CYCLES = 500_000,
   parameter int unsigned NUM_SRC   = debug_pkg::NUM_SRC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        auto_mode,
   input  logic [2:0]  sw_sel,
   input  logic        freeze,
   input  logic        step_key,
   output logic [2:0]  sel,
   output logic        step_en,
   output logic [15:0] step_count
);

   import debug_pkg::*;

   localparam int unsigned DW = (DWELL > 2) ? $clog2(DWELL) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

   mode_e         mode;
   logic [DW-1:0] dwell;
   logic          key_stable;
   logic          key_rise;

   // Mode FSM with registered select and auto-scan dwell timer.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode  <= MANUAL;
         sel   <= SEL_RDATA1;
         dwell <= '0;
      end else begin
         case (mode)
            MANUAL: begin
               dwell <= '0;
               if (auto_mode) begin
                  mode <= AUTO;
                  sel  <= (32'(sw_sel) < NUM_SRC) ? sw_sel : SEL_RDATA1;
               end else begin
                  sel <= sw_sel;
               end
            end
            AUTO: begin
               if (!auto_mode) begin
                  mode  <= MANUAL;
                  sel   <= sw_sel;
                  dwell <= '0;
               end else if (!freeze) begin
                  if (dwell == DWELL_LAST) begin
                     dwell <= '0;
                     sel   <= next_sel(sel, NUM_SRC);
                  end else begin
                     dwell <= dwell + 1'b1;
                  end
               end
            end
            default: begin
               mode  <= MANUAL;
               sel   <= SEL_RDATA1;
               dwell <= '0;
            end
         endcase
      end
   end

   key_debouncer #(
      .DB_CYCLES(DB_CYCLES)
   ) u_step_key (
      .clk       (clk),
      .reset     (reset),
      .raw       (step_key),
      .stable    (key_stable),
      .rise_pulse(key_rise)
   );

   // The stable level is always high while a rise pulse is present; qualifying keeps the pulse tied to a pressed key.
   assign step_en = key_rise & key_stable;

   // Count executed steps, wrapping at 16 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         step_count <= '0;
      end else if (step_en) begin
         step_count <= step_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_debug_view_sequencer.sv
// Self-checking bench for debug_view_sequencer with a cycle-level behavioural model.
module tb_debug_view_sequencer;

   localparam int unsigned DWELL = 4;
   localparam int unsigned DB    = 3;
   localparam int unsigned NSRC  = 5;
   localparam int unsigned LAT   = 2 + DB + 1;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        auto_mode = 1'b0;
   logic [2:0]  sw_sel = 3'd0;
   logic        freeze = 1'b0;
   logic        step_key = 1'b0;
   logic [2:0]  sel;
   logic        step_en;
   logic [15:0] step_count;

   int total = 0;
   int bad   = 0;

   // Model state: mode, auto-scan origin and number of unfrozen auto cycles.
   bit          m_auto;
   int unsigned m_base;
   int unsigned m_active;
   logic [2:0]  m_sel;
   // Key model: delay line, accepted level, run of differing samples, pending pulse.
   bit          m_s1, m_s2, m_stable, m_rise, m_en;
   int unsigned m_diff;
   logic [15:0] m_count;

   debug_view_sequencer #(
      .DWELL    (DWELL),
      .DB_CYCLES(DB),
      .NUM_SRC  (NSRC)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .auto_mode (auto_mode),
      .sw_sel    (sw_sel),
      .freeze    (freeze),
      .step_key  (step_key),
      .sel       (sel),
      .step_en   (step_en),
      .step_count(step_count)
   );

   always #5 clk = ~clk;

   // Advance the reference model by one clock using the inputs seen at this edge.
   task automatic model_step();
      bit old_en;
      if (reset) begin
         m_auto = 0; m_base = 0; m_active = 0; m_sel = 3'd0;
         m_s1 = 0; m_s2 = 0; m_stable = 0; m_rise = 0; m_en = 0; m_diff = 0;
         m_count = 16'd0;
      end else begin
         if (!m_auto) begin
            if (auto_mode) begin
               m_auto   = 1;
               m_base   = (sw_sel < NSRC) ? int'(sw_sel) : 0;
               m_active = 0;
               m_sel    = 3'(m_base);
            end else begin
               m_sel = sw_sel;
            end
         end else if (!auto_mode) begin
            m_auto = 0;
            m_sel  = sw_sel;
         end else if (!freeze) begin
            m_active++;
            m_sel = 3'((m_base + m_active / DWELL) % NSRC);
         end
         old_en = m_en;
         m_en   = m_rise;
         m_rise = 0;
         if (m_s2 != m_stable) begin
            m_diff++;
            if (m_diff == DB) begin
               m_stable = m_s2;
               m_diff   = 0;
               m_rise   = m_stable;
            end
         end else begin
            m_diff = 0;
         end
         m_s2 = m_s1;
         m_s1 = step_key;
         if (old_en) m_count = m_count + 16'd1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      total++; if (sel !== 3'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", sel); end
      total++; if (step_en !== 1'b0) begin bad++; $display("FAIL reset_step_en got=%0b exp=0", step_en); end
      total++; if (step_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%h exp=0000", step_count); end
      reset = 1'b0;
   endtask

   task automatic test_manual();
      auto_mode = 1'b0;
      sw_sel = 3'b011;
      tick();
      total++; if (sel !== 3'd3) begin bad++; $display("FAIL manual_sel3 got=%0d exp=3", sel); end
      sw_sel = 3'b110;
      tick();
      total++; if (sel !== 3'd6) begin bad++; $display("FAIL manual_sel6 got=%0d exp=6", sel); end
      total++; if (step_en !== 1'b0 || step_count !== 16'd0) begin
         bad++; $display("FAIL manual_step got_en=%0b got_cnt=%h exp_en=0 exp_cnt=0000", step_en, step_count);
      end
   endtask

   task automatic test_auto_scan();
      int unsigned expv;
      sw_sel = 3'b010;
      auto_mode = 1'b1;
      for (int unsigned i = 0; i < 24; i++) begin
         tick();
         expv = (2 + i / DWELL) % NSRC;
         total++; if (sel !== 3'(expv)) begin bad++; $display("FAIL auto_scan i=%0d got=%0d exp=%0d", i, sel, expv); end
         total++; if (sel > 3'd4) begin bad++; $display("FAIL auto_range i=%0d got=%0d exp<=4", i, sel); end
      end
      auto_mode = 1'b0;
      tick();
   endtask

   task automatic test_freeze();
      int unsigned n;
      sw_sel = 3'b111;
      auto_mode = 1'b1;
      tick();
      total++; if (sel !== 3'd0) begin bad++; $display("FAIL freeze_entry got=%0d exp=0", sel); end
      tick(); tick();
      freeze = 1'b1;
      for (int unsigned i = 0; i < 10; i++) begin
         tick();
         total++; if (sel !== 3'd0) begin bad++; $display("FAIL freeze_hold i=%0d got=%0d exp=0", i, sel); end
      end
      freeze = 1'b0;
      n = 0;
      while (sel == 3'd0 && n < 10) begin
         tick();
         n++;
      end
      total++; if (n != DWELL - 2) begin bad++; $display("FAIL freeze_resume got=%0d cycles exp=%0d", n, DWELL - 2); end
      total++; if (sel !== 3'd1) begin bad++; $display("FAIL freeze_next got=%0d exp=1", sel); end
      auto_mode = 1'b0;
      tick();
   endtask

   task automatic test_step_press();
      int unsigned pulses, first;
      pulses = 0; first = 0;
      step_key = 1'b1;
      for (int unsigned i = 1; i <= 20; i++) begin
         tick();
         if (step_en === 1'b1) begin
            pulses++;
            if (first == 0) first = i;
         end
      end
      total++; if (pulses != 1) begin bad++; $display("FAIL press_pulses got=%0d exp=1", pulses); end
      total++; if (first != LAT) begin bad++; $display("FAIL press_latency got=%0d exp=%0d", first, LAT); end
      total++; if (step_count !== 16'd1) begin bad++; $display("FAIL press_count1 got=%h exp=0001", step_count); end
      step_key = 1'b0;
      pulses = 0;
      for (int unsigned i = 0; i < 12; i++) begin
         tick();
         if (step_en === 1'b1) pulses++;
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL release_pulse got=%0d exp=0", pulses); end
      step_key = 1'b1;
      repeat (20) tick();
      step_key = 1'b0;
      repeat (12) tick();
      total++; if (step_count !== 16'd2) begin bad++; $display("FAIL press_count2 got=%h exp=0002", step_count); end
   endtask

   task automatic test_glitch();
      int unsigned pulses;
      pulses = 0;
      step_key = 1'b1;
      tick(); tick();
      step_key = 1'b0;
      for (int unsigned i = 0; i < 12; i++) begin
         tick();
         if (step_en === 1'b1) pulses++;
      end
      total++; if (pulses != 0) begin bad++; $display("FAIL glitch_pulse got=%0d exp=0", pulses); end
      total++; if (step_count !== 16'd2) begin bad++; $display("FAIL glitch_count got=%h exp=0002", step_count); end
   endtask

   task automatic test_wrap();
      force dut.step_count = 16'hFFFF;
      m_count = 16'hFFFF;
      tick();
      release dut.step_count;
      tick();
      total++; if (step_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=ffff", step_count); end
      step_key = 1'b1;
      repeat (20) tick();
      step_key = 1'b0;
      repeat (12) tick();
      total++; if (step_count !== 16'h0000) begin bad++; $display("FAIL wrap_count got=%h exp=0000", step_count); end
   endtask

   task automatic test_reset_mid_debounce();
      int unsigned pulses, first;
      auto_mode = 1'b1;
      sw_sel = 3'd3;
      repeat (6) tick();
      step_key = 1'b1;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      total++; if (step_en !== 1'b0) begin bad++; $display("FAIL midrst_en got=%0b exp=0", step_en); end
      total++; if (sel !== 3'd0) begin bad++; $display("FAIL midrst_sel got=%0d exp=0", sel); end
      total++; if (step_count !== 16'd0) begin bad++; $display("FAIL midrst_count got=%h exp=0000", step_count); end
      reset = 1'b0;
      auto_mode = 1'b0;
      pulses = 0; first = 0;
      for (int unsigned i = 1; i <= 20; i++) begin
         tick();
         if (step_en === 1'b1) begin
            pulses++;
            if (first == 0) first = i;
         end
      end
      total++; if (pulses != 1 || first != LAT) begin
         bad++; $display("FAIL midrst_pulse got_n=%0d got_at=%0d exp_n=1 exp_at=%0d", pulses, first, LAT);
      end
      total++; if (step_count !== 16'd1) begin bad++; $display("FAIL midrst_count1 got=%h exp=0001", step_count); end
      step_key = 1'b0;
      repeat (12) tick();
   endtask

   task automatic test_random();
      int unsigned run;
      run = 0;
      for (int unsigned i = 0; i < 800; i++) begin
         if (run == 0) begin
            step_key = 1'($urandom_range(0, 1));
            run = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 14) : $urandom_range(1, 5);
         end
         run--;
         if ($urandom_range(0, 29) == 0) auto_mode = ~auto_mode;
         if ($urandom_range(0, 7) == 0) freeze = ~freeze;
         if ($urandom_range(0, 3) == 0) sw_sel = 3'($urandom_range(0, 7));
         reset = ($urandom_range(0, 249) == 0);
         tick();
         total++; if (sel !== m_sel) begin bad++; $display("FAIL rand_sel i=%0d got=%0d exp=%0d", i, sel, m_sel); end
         total++; if (step_en !== m_en) begin bad++; $display("FAIL rand_en i=%0d got=%0b exp=%0b", i, step_en, m_en); end
         total++; if (step_count !== m_count) begin bad++; $display("FAIL rand_count i=%0d got=%h exp=%h", i, step_count, m_count); end
      end
      reset = 1'b0;
   endtask

   initial begin
      test_reset();
      test_manual();
      test_auto_scan();
      test_freeze();
      test_step_press();
      test_glitch();
      test_wrap();
      test_reset_mid_debounce();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
